uart_byte_tx: RTL and testbench

//  Serial UART transmitter that consumes the random-byte stream (random_Byte/valid_Sig)
//  and drives an 8N1 frame onto tx_Serial. Returns tx_Done, a level "idle/ready" signal,
//  to the byte producer so a new byte is only issued when the line is free. Sits between
//  the random-number filter top and the board TX pin. Single clock domain: low_Freq_Clk.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_byte_tx.sv | 150 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the uart_byte_tx transmitter.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frame).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == DROP_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tc on the last count.
// Build option UART_TX_PARITY_EN does not affect this block.
module uart_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic low_Freq_Clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == CNT_LAST);

  always_ff @(posedge low_Freq_Clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter for the random-byte stream; counts bytes offered while busy.
// Build option: define UART_TX_PARITY_EN for an even-parity bit after the data bits.
module uart_byte_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       low_Freq_Clk,
  input  logic       reset,
  input  logic       valid_Sig,
  input  logic [7:0] random_Byte,
  output logic       tx_Serial,
  output logic       tx_Active,
  output logic       tx_Done,
  output logic [7:0] drop_Count
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state, state_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [2:0] bit_q, bit_nxt;
  logic       serial_nxt, active_nxt, done_nxt;
  logic [7:0] drop_nxt;
  logic       cnt_en, cnt_clr, bit_tc;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_nxt;
`endif

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .low_Freq_Clk(low_Freq_Clk),
    .reset       (reset),
    .en          (cnt_en),
    .clr         (cnt_clr),
    .tc          (bit_tc)
  );

  // The counter is held at zero in IDLE so START gets a full bit period from the accepting edge.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    bit_nxt    = bit_q;
    serial_nxt = tx_Serial;
    active_nxt = tx_Active;
    done_nxt   = tx_Done;
    drop_nxt   = drop_Count;
    cnt_en     = (state != IDLE);
    cnt_clr    = (state == IDLE);
`ifdef UART_TX_PARITY_EN
    par_nxt    = par_q;
`endif

    if (valid_Sig && (state != IDLE)) begin
      drop_nxt = sat_inc(drop_Count);
    end

    case (state)
      IDLE: begin
        serial_nxt = 1'b1;
        if (valid_Sig) begin
          state_nxt  = START;
          shift_nxt  = random_Byte;
          bit_nxt    = 3'd0;
          serial_nxt = 1'b0;
          active_nxt = 1'b1;
          done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt    = ^random_Byte;
`endif
        end
      end
      START: begin
        if (bit_tc) begin
          state_nxt  = DATA;
          serial_nxt = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tc) begin
          if (bit_q == LAST_BIT) begin
            bit_nxt    = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_nxt  = PARITY;
            serial_nxt = par_q;
`else
            state_nxt  = STOP;
            serial_nxt = 1'b1;
`endif
          end else begin
            bit_nxt    = bit_q + 3'd1;
            shift_nxt  = {1'b0, shift_q[7:1]};
            serial_nxt = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tc) begin
          state_nxt  = STOP;
          serial_nxt = 1'b1;
        end
      end
      STOP: begin
        if (bit_tc) begin
          state_nxt  = IDLE;
          active_nxt = 1'b0;
          done_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        serial_nxt = 1'b1;
        active_nxt = 1'b0;
        done_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge low_Freq_Clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      tx_Serial  <= 1'b1;
      tx_Active  <= 1'b0;
      tx_Done    <= 1'b1;
      drop_Count <= '0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bit_q      <= bit_nxt;
      tx_Serial  <= serial_nxt;
      tx_Active  <= active_nxt;
      tx_Done    <= done_nxt;
      drop_Count <= drop_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge low_Freq_Clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Honours UART_TX_PARITY_EN when the bench is compiled with the same define as the RTL.
module tb_uart_byte_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid_Sig;
  logic [7:0] random_Byte;
  logic       sel;

  logic       v4, v1;
  logic       ser4, act4, done4, ser1, act1, done1;
  logic [7:0] drop4, drop1;
  logic       ser_m, act_m, done_m;
  logic [7:0] drop_m;
  int         cpb_m;

  assign v4     = valid_Sig && !sel;
  assign v1     = valid_Sig && sel;
  assign ser_m  = sel ? ser1  : ser4;
  assign act_m  = sel ? act1  : act4;
  assign done_m = sel ? done1 : done4;
  assign drop_m = sel ? drop1 : drop4;
  assign cpb_m  = sel ? 1 : 4;

  uart_byte_tx #(.CLKS_PER_BIT(4)) dut4 (
    .low_Freq_Clk(clk), .reset(reset), .valid_Sig(v4), .random_Byte(random_Byte),
    .tx_Serial(ser4), .tx_Active(act4), .tx_Done(done4), .drop_Count(drop4)
  );

  uart_byte_tx #(.CLKS_PER_BIT(1)) dut1 (
    .low_Freq_Clk(clk), .reset(reset), .valid_Sig(v1), .random_Byte(random_Byte),
    .tx_Serial(ser1), .tx_Active(act1), .tx_Done(done1), .drop_Count(drop1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a byte is accepted on the first edge at or after next_free,
  // after which the line is busy for FRAME*cpb cycles plus the closing idle edge.
  logic [7:0] exp_q[$];
  int edge_n = 0;
  int next_free = 0;
  int model_drops = 0;
  int model_accepts = 0;

  task automatic model_edge(input logic v, input logic [7:0] b);
    edge_n++;
    if (v && reset) begin
      if (edge_n >= next_free) begin
        exp_q.push_back(b);
        model_accepts++;
        next_free = edge_n + FRAME * cpb_m + 1;
      end else if (model_drops < 255) begin
        model_drops++;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    valid_Sig   = v;
    random_Byte = b;
    @(posedge clk);
    model_edge(v, b);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (FRAME == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Monitor: decodes frames off the line and checks them against the scoreboard queue.
  logic       in_frame = 1'b0;
  logic       end_pending = 1'b0;
  logic [7:0] cur_byte;
  int         k, bad_k;
  int         idle_cnt = 0;
  int         last_gap = -1;
  int         frames_seen = 0;

  always @(negedge clk) begin
    if (!reset) begin
      in_frame    = 1'b0;
      end_pending = 1'b0;
      idle_cnt    = 0;
      frames_seen = 0;
    end else begin
      if (end_pending) begin
        end_pending = 1'b0;
        chk("frame_bits_first_bad_sample", bad_k, -1);
        chk("frame_end_ser_act_done", int'({ser_m, act_m, done_m}), 5);
        frames_seen++;
        idle_cnt = 1;
      end else if (!in_frame) begin
        if (ser_m === 1'b0) begin
          last_gap = idle_cnt;
          idle_cnt = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_start", 1, 0);
            cur_byte = 8'h00;
          end else begin
            cur_byte = exp_q.pop_front();
          end
          in_frame = 1'b1;
          k        = 0;
          bad_k    = -1;
        end else begin
          idle_cnt++;
        end
      end
      if (in_frame) begin
        if ((ser_m !== exp_bit(cur_byte, k / cpb_m)) || (act_m !== 1'b1) || (done_m !== 1'b0)) begin
          if (bad_k < 0) bad_k = k;
        end
        k++;
        if (k == FRAME * cpb_m) begin
          in_frame    = 1'b0;
          end_pending = 1'b1;
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || end_pending) && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    if (n >= 3000) chk({name, "_drain_timeout"}, 1, 0);
    step(1'b0, 8'h00);
    #1;
    chk({name, "_frames"}, frames_seen, model_accepts);
    chk({name, "_drop_count"}, int'(drop_m), model_drops);
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (edge_n + 1 < next_free && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("reset_line_state", int'({ser_m, act_m, done_m}), 5);
    chk("reset_drop_count", int'(drop_m), 0);
    repeat (3) step(1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_drops   = 0;
    model_accepts = 0;
    next_free     = 0;
  endtask

  initial begin
    logic [7:0] b;
    int hold, gap;
    reset       = 1'b0;
    valid_Sig   = 1'b0;
    random_Byte = 8'h00;
    sel         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    repeat (20) step(1'b0, 8'h00);
    #1;
    chk("idle_after_reset_ser_act_done", int'({ser_m, act_m, done_m}), 5);
    chk("idle_after_reset_drop", int'(drop_m), 0);

    step(1'b1, 8'hA5);
    drain("single_a5");

    repeat (3) step(1'b1, 8'h3C);
    drain("held_3c");
    chk("held_3c_drop_is_2", int'(drop_m), 2);

    step(1'b1, 8'hC3);
    repeat (16) step(1'b0, $urandom_range(0, 255));
    apply_reset();
    repeat (30) step(1'b0, 8'h00);
    #1;
    chk("no_resume_after_reset", int'({ser_m, act_m, done_m}), 5);
    step(1'b1, 8'h5A);
    drain("fresh_after_reset");

    wait_free();
    step(1'b1, 8'h00);
    wait_free();
    step(1'b1, 8'hFF);
    drain("back_to_back");
    chk("back_to_back_gap", last_gap, 1);

    repeat (25) begin
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        b = 8'($urandom);
        step(1'b1, b);
      end
      gap = $urandom_range(0, 60);
      repeat (gap) step(1'b0, 8'($urandom));
      if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
    end
    drain("random");

    apply_reset();
    sel = 1'b1;
    repeat (3) step(1'b0, 8'h00);
    repeat (330) step(1'b1, 8'($urandom));
    drain("cpb1_saturate");
    chk("cpb1_drop_saturated", int'(drop_m), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
